// File: rtl/velocity_estimator.sv
// velocity_estimator: samples an encoder position every SAMPLE_DIV clocks, clamps the
// per-sample delta and averages it over a 2^AVG_LOG2-deep moving window.
module velocity_estimator #(
    parameter int SAMPLE_DIV = 100000,
    parameter int AVG_LOG2   = 3,
    parameter int MAX_DELTA  = 65535
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic signed [31:0] position,
    input  logic               clear_fault,
    output logic signed [31:0] velocity,
    output logic signed [31:0] delta,
    output logic               vel_valid,
    output logic               avg_ready,
    output logic               fault
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int CW    = $clog2(SAMPLE_DIV);
    localparam int PW    = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int AW    = 32 + AVG_LOG2;
    localparam logic signed [31:0] LIM  = 32'(MAX_DELTA);
    localparam logic [AVG_LOG2:0]  FULL = (AVG_LOG2 + 1)'(DEPTH);

    logic                 running;
    logic                 start;
    logic                 tick;
    logic                 s1_valid;
    logic [CW-1:0]        cnt;
    logic signed [31:0]   prev_pos;
    logic signed [31:0]   raw;
    logic signed [31:0]   clamped;
    logic                 clamp_hi;
    logic                 clamp_lo;
    logic signed [31:0]   ring [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        wr_ptr_next;
    logic [AVG_LOG2:0]    fill;
    logic [AVG_LOG2:0]    fill_next;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;

    always_comb begin
        start       = enable && !running;
        tick        = enable && running && (cnt == CW'(SAMPLE_DIV - 1));
        raw         = position - prev_pos;
        clamp_hi    = raw > LIM;
        clamp_lo    = raw < -LIM;
        clamped     = clamp_hi ? LIM : clamp_lo ? -LIM : raw;
        acc_next    = acc + AW'(delta) - AW'(ring[wr_ptr]);
        wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        fill_next   = (fill == FULL) ? fill : fill + 1'b1;
    end

    // Stage 1 registers the clamped delta on the tick edge; stage 2 folds it into the window one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running   <= 1'b0;
            s1_valid  <= 1'b0;
            cnt       <= '0;
            prev_pos  <= '0;
            delta     <= '0;
            velocity  <= '0;
            acc       <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            vel_valid <= 1'b0;
            avg_ready <= 1'b0;
            fault     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else begin
            running   <= enable;
            s1_valid  <= tick;
            vel_valid <= 1'b0;
            fault     <= (tick && (clamp_hi || clamp_lo)) ? 1'b1 : clear_fault ? 1'b0 : fault;
            if (start) begin
                prev_pos  <= position;
                cnt       <= '0;
                acc       <= '0;
                wr_ptr    <= '0;
                fill      <= '0;
                avg_ready <= 1'b0;
                for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
            end else if (enable) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (tick) begin
                prev_pos <= position;
                delta    <= clamped;
            end
            if (s1_valid) begin
                acc          <= acc_next;
                ring[wr_ptr] <= delta;
                wr_ptr       <= wr_ptr_next;
                fill         <= fill_next;
                avg_ready    <= fill_next == FULL;
                velocity     <= 32'(acc_next >>> AVG_LOG2);
                vel_valid    <= 1'b1;
            end
        end
    end
endmodule

// File: doc/velocity_estimator.md
VELOCITY_ESTIMATOR -- requirements
Module: velocity_estimator

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000, clk cycles per velocity sample (1 kHz at 100 MHz); legal range >= 4.
REQ-002 Parameter AVG_LOG2, default 3, log2 of moving-average depth (depth 8); legal range 0..5.
REQ-003 Parameter MAX_DELTA, default 65535, positive magnitude limit on a per-sample delta.
REQ-004 clk  input  1  system clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  estimator run; low holds the block idle.
REQ-007 position  input  32 signed  encoder position count, synchronous to clk.
REQ-008 clear_fault  input  1  single-cycle clear of sticky fault.
REQ-009 velocity  output  32 signed  averaged counts per sample period.
REQ-010 delta  output  32 signed  latest clamped per-sample delta.
REQ-011 vel_valid  output  1  one-cycle strobe when velocity/delta update.
REQ-012 avg_ready  output  1  averaging window fully populated.
REQ-013 fault  output  1  sticky; set when any delta was clamped.

Function
REQ-014 The first cycle with enable high after reset or after enable low is the start cycle E: prev_pos SHALL capture position, the sample counter SHALL load 0, the ring buffer, accumulator and fill count SHALL clear, and avg_ready SHALL go low.
REQ-015 From E+1 the counter SHALL increment every cycle; a tick SHALL occur in the cycle the counter equals SAMPLE_DIV-1, after which it SHALL wrap to 0, so ticks fall at E+SAMPLE_DIV, E+2*SAMPLE_DIV, ...
REQ-016 On a tick, raw delta SHALL be position minus prev_pos in 32-bit modulo arithmetic interpreted as signed, and prev_pos SHALL take position.
REQ-017 Stage 1 (tick+1): delta SHALL register the raw delta clamped to [-MAX_DELTA, +MAX_DELTA]; on clamping fault SHALL set.
REQ-018 Stage 2 (tick+2): the accumulator, (32+AVG_LOG2) bits signed, SHALL update to accumulator + delta - oldest buffer entry; delta SHALL overwrite that entry; the write pointer SHALL advance modulo 2^AVG_LOG2.
REQ-019 In the same stage-2 cycle velocity SHALL take the new accumulator arithmetically shifted right by AVG_LOG2 (floor toward minus infinity), and vel_valid SHALL pulse for exactly one cycle.
REQ-020 Fill count SHALL saturate at 2^AVG_LOG2; avg_ready SHALL go high in the stage-2 cycle of the 2^AVG_LOG2-th sample and stay high until REQ-014 or reset; before that, empty entries count as zero.
REQ-021 With enable low the counter SHALL hold at 0 and no tick SHALL occur; a tick already taken SHALL complete stages 1-2; velocity, delta, avg_ready and fault SHALL otherwise hold.
REQ-022 clear_fault SHALL clear fault the next cycle; a clamp in the same cycle SHALL win (fault stays 1).
REQ-023 With AVG_LOG2=0 velocity SHALL equal delta at every vel_valid.

Reset
REQ-024 On reset_n low, asynchronously: velocity, delta, accumulator, buffer, prev_pos, counter, fill count = 0; vel_valid, avg_ready, fault = 0; block waits for enable per REQ-014.
REQ-025 Reset asserted mid-pipeline SHALL discard in-flight samples; no vel_valid SHALL follow release until a new tick completes.

Verification (SAMPLE_DIV=10, AVG_LOG2=2, MAX_DELTA=1000)
REQ-026 enable high at E, position held at 0 -> vel_valid at E+12, E+22, ...; velocity=0, delta=0, fault=0.
REQ-027 position increasing by 5 each sample -> velocity 1, 2, 3, 5 on successive strobes; avg_ready rises with the 4th; then steady 5.
REQ-028 prev_pos 0x7FFFFFFE, next sample 0x80000003 -> delta=+5, no fault; a single -3 delta from a cleared window -> velocity=-1.
REQ-029 position jumps +5000 in one sample -> delta=+1000, fault=1; clear_fault pulsed in the same cycle as a second clamp -> fault stays 1; clear_fault alone -> fault=0.
REQ-030 enable dropped 3 cycles after a tick, then raised -> that sample still strobes; a fresh start cycle follows with buffer cleared and avg_ready=0.
REQ-031 reset_n pulsed one cycle after a tick -> all outputs 0 immediately; no vel_valid until SAMPLE_DIV+2 cycles after the next start cycle.
